// File: rtl/shift_reg_pipe.sv
// Parameterised shift register pipeline with parallel load, synchronous clear,
// per-stage valid tracking and a saturating occupancy count.
module shift_reg_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [1:0]               mode,
   input  logic [WIDTH-1:0]         d,
   input  logic [WIDTH*DEPTH-1:0]   load_data,
   output logic [WIDTH-1:0]         q,
   output logic [WIDTH*DEPTH-1:0]   q_all,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                     full,
   output logic                     q_valid
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_SHIFT = 2'b01;
   localparam logic [1:0] MODE_LOAD  = 2'b10;
   localparam logic [1:0] MODE_CLEAR = 2'b11;

   logic [WIDTH*DEPTH-1:0] stage_q;
   logic [DEPTH-1:0]       valid_q;
   logic [CW-1:0]          count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_q <= '0;
         valid_q <= '0;
         count_q <= '0;
      end else if (en) begin
         case (mode)
            MODE_SHIFT: begin
               // Loop form keeps DEPTH=1 legal (no zero-width slice).
               stage_q[0 +: WIDTH] <= d;
               valid_q[0]          <= 1'b1;
               for (int unsigned i = 1; i < DEPTH; i++) begin
                  stage_q[i*WIDTH +: WIDTH] <= stage_q[(i-1)*WIDTH +: WIDTH];
                  valid_q[i]                <= valid_q[i-1];
               end
               if (count_q != COUNT_MAX) begin
                  count_q <= count_q + 1'b1;
               end
            end
            MODE_LOAD: begin
               stage_q <= load_data;
               valid_q <= '1;
               count_q <= COUNT_MAX;
            end
            MODE_CLEAR: begin
               stage_q <= '0;
               valid_q <= '0;
               count_q <= '0;
            end
            MODE_HOLD: begin
               stage_q <= stage_q;
            end
            default: begin
               stage_q <= stage_q;
            end
         endcase
      end
   end

   assign q       = stage_q[(DEPTH-1)*WIDTH +: WIDTH];
   assign q_all   = stage_q;
   assign count   = count_q;
   assign full    = (count_q == COUNT_MAX);
   assign q_valid = valid_q[DEPTH-1];

endmodule

// File: doc/shift_reg_pipe.md
SHIFT_REG_PIPE -- requirements
Module: shift_reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4, number of register stages; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  asynchronous, active-low reset; low SHALL clear all state immediately, independent of clk.
REQ-005 en  input  1  clock enable; low SHALL hold all state regardless of mode.
REQ-006 mode  input  2  operation select: 00 HOLD, 01 SHIFT, 10 LOAD, 11 CLEAR.
REQ-007 d  input  WIDTH  serial word shifted into stage 0.
REQ-008 load_data  input  WIDTH*DEPTH  parallel load bus; stage i is load_data[i*WIDTH +: WIDTH].
REQ-009 q  output  WIDTH  contents of stage DEPTH-1 (oldest word).
REQ-010 q_all  output  WIDTH*DEPTH  all stages, same packing as load_data.
REQ-011 count  output  $clog2(DEPTH+1)  number of valid words held, 0..DEPTH.
REQ-012 full  output  1  high when count == DEPTH.
REQ-013 q_valid  output  1  high when stage DEPTH-1 holds a valid word.

Function
REQ-014 State: DEPTH stages s[0..DEPTH-1] of WIDTH bits, a count register and one valid bit per stage; no other state.
REQ-015 All outputs SHALL be driven directly from registers or from combinational decode of registers; no combinational path from inputs to outputs.
REQ-016 en=0: every register SHALL hold, for all mode values.
REQ-017 en=1, HOLD: every register SHALL hold.
REQ-018 en=1, SHIFT: s[0]<=d and s[i]<=s[i-1] for i=1..DEPTH-1; valid bits SHALL shift identically, with 1 entering stage 0.
REQ-019 SHIFT count: count<=count+1, saturating at DEPTH; when full, the word in s[DEPTH-1] SHALL be discarded and count SHALL remain DEPTH.
REQ-020 en=1, LOAD: every stage SHALL take its load_data slice in the same edge; all valid bits SHALL be set to 1 and count<=DEPTH.
REQ-021 en=1, CLEAR: every stage, every valid bit and count SHALL become 0 on the edge (synchronous clear).
REQ-022 Latency: a word presented on d with SHIFT SHALL appear on q after exactly DEPTH enabled SHIFT edges; non-shift or disabled cycles SHALL not advance it.
REQ-023 LOAD latency: load_data SHALL be visible on q_all and q one edge after the LOAD edge.
REQ-024 full SHALL equal (count == DEPTH); q_valid SHALL equal the valid bit of stage DEPTH-1.
REQ-025 DEPTH=1: SHIFT SHALL act as a single enabled D register; count SHALL be 0 or 1; full and q_valid SHALL be equal.
REQ-026 The count width SHALL hold DEPTH exactly without overflow for every legal DEPTH, including powers of two.

Reset
REQ-027 While rst=0: all stages, q, q_all, valid bits, count, full and q_valid SHALL be 0, asynchronously, overriding en and mode.
REQ-028 Reset asserted mid-operation (including within a LOAD or SHIFT cycle) SHALL discard all contents; no partial update SHALL survive.
REQ-029 After rst rises, the first rising clk edge SHALL be the first edge able to change state.

Verification (WIDTH=8, DEPTH=4)
REQ-030 Reset: drive rst=0 with clk running, en=1, mode=01, d=8'hFF -> q_all=0, count=0, full=0, q_valid=0 throughout; release -> state changes only from the next edge.
REQ-031 Shift/latency: en=1, mode=01, d=8'h11,22,33,44 on four edges -> q=8'h11 and q_valid=1 after the 4th edge, count=1,2,3,4, full=1 after the 4th edge only.
REQ-032 Saturation: from REQ-031, shift d=8'h55 -> q=8'h22, q_all stage0=8'h55, count stays 4, full stays 1.
REQ-033 Load then clear: mode=10, load_data=32'hDDCCBBAA -> q=8'hDD, count=4; next edge mode=11 -> q_all=0, count=0, q_valid=0.
REQ-034 Enable/hold: from full state, en=0 with mode=01/10/11 cycled for 3 edges, then en=1 mode=00 for 2 edges -> q_all, count unchanged throughout.
REQ-035 Async reset mid-shift: after 2 shifts (count=2) assert rst=0 between clk edges -> all outputs 0 immediately, before the next clk edge.
